huff_encoder_n: RTL and testbench

HUFF_ENCODER_N -- requirements
Module: huff_encoder_n

---
 rtl/huff_encoder_n.sv | 151 +++++++++++++++
 tb/tb_huff_encoder_n.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_encoder_n.sv
// Vector Huffman encoder: loads NUM_SYM char/freq pairs, builds the code tree with
// one merge per cycle, then streams one code word per leaf in arrival order.
module huff_encoder_n #(
    parameter int NUM_SYM = 3,
    parameter int CHAR_W  = 8,
    parameter int FREQ_W  = 3,
    parameter int CODE_W  = NUM_SYM - 1,
    parameter int LEN_W   = $clog2(NUM_SYM) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    input  logic [FREQ_W-1:0] in_freq,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CHAR_W-1:0] out_char,
    output logic [LEN_W-1:0]  out_len,
    output logic [CODE_W-1:0] out_code,
    output logic [CODE_W-1:0] out_mask,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int IDX_W = $clog2(NUM_SYM);
    localparam int WGT_W = FREQ_W + 3;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SYM - 1);
    localparam logic [IDX_W-1:0] BUILD_END = IDX_W'(NUM_SYM - 2);

    typedef enum logic [1:0] {S_LOAD, S_BUILD, S_EMIT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    logic [CHAR_W-1:0]  leaf_char [NUM_SYM];
    logic [CODE_W-1:0]  leaf_code [NUM_SYM];
    logic [LEN_W-1:0]   leaf_len  [NUM_SYM];
    logic [IDX_W-1:0]   leaf_grp  [NUM_SYM];
    logic [WGT_W-1:0]   grp_w     [NUM_SYM];
    logic [NUM_SYM-1:0] grp_act;

    logic               accept, out_hs;
    logic [IDX_W-1:0]   min1, min2;
    logic [WGT_W-1:0]   best1, best2;
    logic               found1, found2;

    assign in_ready = (state_q == S_LOAD);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Cnt doubles as load index, merge counter and emit index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOAD: if (accept) begin
                state_d = (cnt_q == LAST_IDX) ? S_BUILD : S_LOAD;
                cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_W'(1);
            end
            S_BUILD: begin
                state_d = (cnt_q == BUILD_END) ? S_EMIT : S_BUILD;
                cnt_d   = (cnt_q == BUILD_END) ? '0 : cnt_q + IDX_W'(1);
            end
            S_EMIT: if (out_hs) begin
                state_d = (cnt_q == LAST_IDX) ? S_LOAD : S_EMIT;
                cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_W'(1);
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Two lightest active groups; strict compare keeps the lowest index on ties.
    always_comb begin
        min1   = '0;
        min2   = '0;
        best1  = '0;
        best2  = '0;
        found1 = 1'b0;
        found2 = 1'b0;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (grp_act[i] && (!found1 || grp_w[i] < best1)) begin
                min1   = IDX_W'(i);
                best1  = grp_w[i];
                found1 = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SYM; i++) begin
            if (grp_act[i] && IDX_W'(i) != min1 && (!found2 || grp_w[i] < best2)) begin
                min2   = IDX_W'(i);
                best2  = grp_w[i];
                found2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the leaf/group arrays are reset explicitly so no stale vector survives a reset.
            for (int j = 0; j < NUM_SYM; j++) begin
                leaf_char[j] <= '0;
                leaf_code[j] <= '0;
                leaf_len[j]  <= '0;
                leaf_grp[j]  <= '0;
                grp_w[j]     <= '0;
            end
            grp_act <= '0;
        end else if (accept) begin
            leaf_char[cnt_q] <= in_char;
            leaf_code[cnt_q] <= '0;
            leaf_len[cnt_q]  <= '0;
            leaf_grp[cnt_q]  <= cnt_q;
            grp_w[cnt_q]     <= WGT_W'(in_freq);
            grp_act[cnt_q]   <= 1'b1;
        end else if (state_q == S_BUILD) begin
            for (int j = 0; j < NUM_SYM; j++) begin
                if (leaf_grp[j] == min1) begin
                    leaf_len[j] <= leaf_len[j] + LEN_W'(1);
                end else if (leaf_grp[j] == min2) begin
                    leaf_code[j] <= leaf_code[j] | (CODE_W'(1) << leaf_len[j]);
                    leaf_len[j]  <= leaf_len[j] + LEN_W'(1);
                    leaf_grp[j]  <= min1;
                end
            end
            grp_w[min1]   <= best1 + best2;
            grp_act[min2] <= 1'b0;
        end
    end

    assign out_valid = (state_q == S_EMIT);
    assign out_char  = out_valid ? leaf_char[cnt_q] : '0;
    assign out_len   = out_valid ? leaf_len[cnt_q]  : '0;
    assign out_code  = out_valid ? leaf_code[cnt_q] : '0;
    assign out_mask  = out_valid ? ~({CODE_W{1'b1}} << leaf_len[cnt_q]) : '0;
    assign out_last  = out_valid && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_huff_encoder_n.sv
// Bench for huff_encoder_n: 3- and 4-symbol instances driven from shared stimulus,
// directed cases plus random vectors scored against a set-based Huffman model.
module tb_huff_encoder_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_char;
    logic [2:0] in_freq;
    logic       out_ready;
    logic       sel;

    logic       in_ready3, out_valid3, out_last3;
    logic [7:0] out_char3;
    logic [2:0] out_len3;
    logic [1:0] out_code3, out_mask3;
    logic       in_ready4, out_valid4, out_last4;
    logic [7:0] out_char4;
    logic [2:0] out_len4;
    logic [2:0] out_code4, out_mask4;

    logic       in_ready, out_valid, out_last;
    logic [7:0] out_char;
    logic [2:0] out_len, out_code, out_mask;

    always #5 clk = ~clk;

    huff_encoder_n #(.NUM_SYM(3), .CHAR_W(8), .FREQ_W(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid && !sel), .in_char(in_char),
        .in_freq(in_freq), .in_ready(in_ready3), .out_valid(out_valid3),
        .out_char(out_char3), .out_len(out_len3), .out_code(out_code3),
        .out_mask(out_mask3), .out_last(out_last3), .out_ready(out_ready)
    );

    huff_encoder_n #(.NUM_SYM(4), .CHAR_W(8), .FREQ_W(3)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel), .in_char(in_char),
        .in_freq(in_freq), .in_ready(in_ready4), .out_valid(out_valid4),
        .out_char(out_char4), .out_len(out_len4), .out_code(out_code4),
        .out_mask(out_mask4), .out_last(out_last4), .out_ready(out_ready)
    );

    assign in_ready  = sel ? in_ready4  : in_ready3;
    assign out_valid = sel ? out_valid4 : out_valid3;
    assign out_last  = sel ? out_last4  : out_last3;
    assign out_char  = sel ? out_char4  : out_char3;
    assign out_len   = sel ? out_len4   : out_len3;
    assign out_code  = sel ? out_code4  : {1'b0, out_code3};
    assign out_mask  = sel ? out_mask4  : {1'b0, out_mask3};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] v_char [8];
    int         v_freq [8];
    int         exp_len [8];
    int         exp_code [8];
    int         acc_cyc;
    int         stall_idx = -1;
    int         stall_len = 0;
    bit         rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, {out_char, out_len, out_code, out_mask, out_last}, 0);
    endtask

    // Huffman by explicit leaf sets: each group is a bitmask of leaves.
    task automatic model(input int n);
        int w [8];
        int mem [8];
        bit alive [8];
        int m1, m2;
        for (int j = 0; j < n; j++) begin
            w[j] = v_freq[j]; mem[j] = 1 << j; alive[j] = 1'b1;
            exp_len[j] = 0; exp_code[j] = 0;
        end
        repeat (n - 1) begin
            m1 = -1;
            for (int j = 0; j < n; j++) if (alive[j] && (m1 < 0 || w[j] < w[m1])) m1 = j;
            m2 = -1;
            for (int j = 0; j < n; j++)
                if (alive[j] && j != m1 && (m2 < 0 || w[j] < w[m2])) m2 = j;
            for (int j = 0; j < n; j++) begin
                if (((mem[m2] >> j) & 1) == 1) exp_code[j] += 1 << exp_len[j];
                if ((((mem[m1] | mem[m2]) >> j) & 1) == 1) exp_len[j]++;
            end
            mem[m1] |= mem[m2];
            w[m1] += w[m2];
            alive[m2] = 1'b0;
        end
    endtask

    task automatic load_vec(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_char  = v_char[k];
            in_freq  = 3'(v_freq[k]);
            check("in_ready_load", in_ready, 1);
            acc_cyc = cyc;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic emit_vec(input int n);
        int t = 0;
        int idx = 0;
        int sc = 0;
        while (out_valid !== 1'b1 && t < 64) begin
            check_idle("build_idle");
            step();
            t++;
        end
        check("first_valid", out_valid, 1);
        check("latency", cyc - acc_cyc, n);
        t = 0;
        while (idx < n && t < 200) begin
            if (idx == stall_idx && sc < stall_len) begin
                out_ready = 1'b0;
                sc++;
                in_valid = 1'b1;
                in_char  = 8'($urandom);
                in_freq  = 3'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            check("out_valid", out_valid, 1);
            check("out_char", out_char, v_char[idx]);
            check("out_len", out_len, exp_len[idx]);
            check("out_code", out_code, exp_code[idx]);
            check("out_mask", out_mask, (1 << exp_len[idx]) - 1);
            check("out_last", out_last, (idx == n - 1) ? 1 : 0);
            if (out_ready) idx++;
            step();
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("emit_count", idx, n);
        check("in_ready_after", in_ready, 1);
        check_idle("after_last");
    endtask

    task automatic set3(input logic [7:0] c0, input int f0, input logic [7:0] c1, input int f1,
                        input logic [7:0] c2, input int f2);
        v_char[0] = c0; v_freq[0] = f0;
        v_char[1] = c1; v_freq[1] = f1;
        v_char[2] = c2; v_freq[2] = f2;
    endtask

    task automatic set_abc();
        set3("a", 1, "b", 2, "c", 3);
        exp_len[0] = 2; exp_code[0] = 0;
        exp_len[1] = 2; exp_code[1] = 1;
        exp_len[2] = 1; exp_code[2] = 1;
    endtask

    task automatic reset_pulse();
        #2;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_char  = 8'h5a;
        in_freq  = 3'd1;
        #1;
        check_idle("reset_async");
        step();
        check("in_ready_reset", in_ready, 1);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_idle("post_reset");
            check("in_ready_post_reset", in_ready, 1);
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = '0;
        in_freq   = '0;
        out_ready = 1'b0;
        sel       = 1'b0;
        step();
        in_valid = 1'b1;
        in_char  = 8'hee;
        in_freq  = 3'd5;
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check_idle("reset_state");

        // Basic vector, then tie-rule vector loaded back-to-back.
        set_abc();
        load_vec(3);
        emit_vec(3);
        set3("x", 2, "y", 2, "z", 2);
        exp_len[0] = 2; exp_code[0] = 2;
        exp_len[1] = 2; exp_code[1] = 3;
        exp_len[2] = 1; exp_code[2] = 0;
        load_vec(3);
        emit_vec(3);

        // Back-pressure on the second code with ignored in_valid pulses.
        set_abc();
        stall_idx = 1;
        stall_len = 4;
        load_vec(3);
        emit_vec(3);
        stall_idx = -1;
        stall_len = 0;

        // Four symbols with zero frequencies.
        sel = 1'b1;
        v_char[0] = "p"; v_freq[0] = 0;
        v_char[1] = "q"; v_freq[1] = 0;
        v_char[2] = "r"; v_freq[2] = 0;
        v_char[3] = "s"; v_freq[3] = 7;
        exp_len[0] = 3; exp_code[0] = 0;
        exp_len[1] = 3; exp_code[1] = 1;
        exp_len[2] = 2; exp_code[2] = 1;
        exp_len[3] = 1; exp_code[3] = 1;
        load_vec(4);
        emit_vec(4);
        sel = 1'b0;

        // Reset during BUILD, then a fresh vector.
        set3("d", 4, "e", 4, "f", 4);
        load_vec(3);
        reset_pulse();
        set_abc();
        load_vec(3);
        emit_vec(3);

        // Reset mid-LOAD: partial leaf count must be discarded.
        set3("g", 7, "h", 0, "i", 1);
        load_vec(1);
        reset_pulse();
        set_abc();
        load_vec(3);
        emit_vec(3);

        // Reset during EMIT while stalled.
        set3("j", 5, "k", 6, "l", 7);
        load_vec(3);
        for (int t = 0; t < 8 && out_valid !== 1'b1; t++) step();
        check("emit_before_reset", out_valid, 1);
        reset_pulse();
        set_abc();
        load_vec(3);
        emit_vec(3);

        // Random vectors with random back-pressure.
        rand_ready = 1'b1;
        for (int v = 0; v < 30; v++) begin
            int n;
            sel = 1'($urandom_range(0, 1));
            n = sel ? 4 : 3;
            for (int k = 0; k < n; k++) begin
                v_char[k] = 8'($urandom);
                v_freq[k] = $urandom_range(0, 7);
            end
            model(n);
            if ($urandom_range(0, 3) == 0) begin
                stall_idx = $urandom_range(0, n - 1);
                stall_len = $urandom_range(1, 4);
            end else begin
                stall_idx = -1;
                stall_len = 0;
            end
            load_vec(n);
            emit_vec(n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
